// File: rtl/sigma_pkg.sv
// Shared definitions for the Sigma-style CPU core: opcodes, FSM states,
// instruction field positions (bit 0 = MSB) and condition-code indices.
package sigma_pkg;

    localparam logic [6:0] OP_AI   = 7'h20;
    localparam logic [6:0] OP_LI   = 7'h22;
    localparam logic [6:0] OP_WAIT = 7'h2E;
    localparam logic [6:0] OP_AW   = 7'h30;
    localparam logic [6:0] OP_LW   = 7'h32;
    localparam logic [6:0] OP_BCR  = 7'h68;
    localparam logic [6:0] OP_BCS  = 7'h69;

    typedef enum logic [2:0] {
        FETCH,
        INDIRECT,
        EXEC,
        WAIT,
        TRAP
    } state_t;

    // Field positions in a [0:31] instruction word, first..last bit.
    localparam int I_BIT     = 0;
    localparam int OP_FIRST  = 1;
    localparam int OP_LAST   = 7;
    localparam int R_FIRST   = 8;
    localparam int R_LAST    = 11;
    localparam int X_FIRST   = 12;
    localparam int X_LAST    = 14;
    localparam int A_FIRST   = 15;
    localparam int A_LAST    = 31;
    localparam int IMM_FIRST = 12;

    // Condition-code indices within a [1:4] CC vector.
    localparam int CC1 = 1;
    localparam int CC2 = 2;
    localparam int CC3 = 3;
    localparam int CC4 = 4;

    // Opcodes that reference memory and therefore honour the indirect bit.
    function automatic logic is_memref(input logic [6:0] op);
        return op inside {OP_AW, OP_LW, OP_BCR, OP_BCS};
    endfunction

    // CC1=carry, CC2=overflow, CC3=result>0, CC4=result<0.
    function automatic logic [1:4] cc_value(input logic carry, input logic ovf,
                                            input logic [0:31] v);
        return {carry, ovf, (v[0] == 1'b0) && (v != '0), v[0]};
    endfunction

endpackage

// File: rtl/sigma_regfile.sv
// 16 x 32-bit general registers: R read port, X index read port,
// one synchronous write port, asynchronous active-low clear.
module sigma_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  addr_r,
    input  logic [2:0]  addr_x,
    output logic [0:31] data_r,
    output logic [16:0] index_x,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [0:31] wr_data
);

    logic [15:0][0:31] regs;

    assign data_r  = regs[addr_r];
    // Only the address-sized low part of an index register takes part in EA.
    assign index_x = regs[{1'b0, addr_x}][15:31];

    // Register write; reset clears every register at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sigma_cpu.sv
// Sigma-style 32-bit CPU core: FETCH / INDIRECT / EXEC state machine over a
// combinational-read, word-addressed memory. Halts on WAIT or on a trap.
module sigma_cpu
    import sigma_pkg::*;
#(
    parameter logic [16:0] RESET_PC = 17'h00000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [0:31]  data_in,
    output logic [15:31] address,
    output logic [6:0]   opcode,
    output logic [16:0]  pc,
    output logic         trap,
    output logic         ende
);

    state_t       state, state_nx;
    logic [0:31]  ir;
    logic [16:0]  ref_addr;
    logic [16:0]  q, q_nx;
    logic [1:4]   cc, cc_nx;
    logic         cc_we;
    logic         set_trap;

    logic [0:31]  rd_r;
    logic [16:0]  index_x;
    logic         gpr_we;
    logic [0:31]  gpr_wd;

    logic [6:0]   op;
    logic [2:0]   x_sel;
    logic [0:31]  imm;
    logic [16:0]  ea;
    logic [0:31]  addend;
    logic [32:0]  sum;
    logic         ovf;
    logic         illegal;

    assign op     = ir[OP_FIRST:OP_LAST];
    assign x_sel  = ir[X_FIRST:X_LAST];
    assign imm    = {{12{ir[IMM_FIRST]}}, ir[IMM_FIRST:31]};
    // Indexing is applied on top of the (possibly indirected) reference address.
    assign ea     = ref_addr + ((x_sel != 3'd0) ? index_x : 17'd0);
    assign addend = (op == OP_AI) ? imm : data_in;
    assign sum    = {1'b0, rd_r} + {1'b0, addend};
    assign ovf    = (rd_r[0] == addend[0]) && (sum[31] != rd_r[0]);
    assign illegal = !(op inside {OP_AI, OP_LI, OP_AW, OP_LW, OP_BCR, OP_BCS, OP_WAIT})
                   || (ir[I_BIT] && (op inside {OP_AI, OP_LI, OP_WAIT}));

    assign opcode = op;
    assign pc     = q;

    sigma_regfile u_rf (
        .clock   (clock),
        .reset   (reset),
        .addr_r  (ir[R_FIRST:R_LAST]),
        .addr_x  (x_sel),
        .data_r  (rd_r),
        .index_x (index_x),
        .wr_en   (gpr_we),
        .wr_addr (ir[R_FIRST:R_LAST]),
        .wr_data (gpr_wd)
    );

    // Memory address; kept apart from data_in consumers so no false loop forms.
    always_comb begin
        address = q;
        case (state)
            INDIRECT: address = ir[A_FIRST:A_LAST];
            EXEC:     address = ea;
            default:  address = q;
        endcase
    end

    // Next-state, register/CC writes, branch and completion pulse.
    always_comb begin
        state_nx = state;
        q_nx     = q;
        ende     = 1'b0;
        gpr_we   = 1'b0;
        gpr_wd   = '0;
        cc_we    = 1'b0;
        cc_nx    = cc;
        set_trap = 1'b0;
        case (state)
            FETCH: begin
                q_nx     = q + 17'd1;
                state_nx = (data_in[I_BIT] && is_memref(data_in[OP_FIRST:OP_LAST]))
                         ? INDIRECT : EXEC;
            end
            INDIRECT: state_nx = EXEC;
            EXEC: begin
                if (illegal) begin
                    set_trap = 1'b1;
                    state_nx = TRAP;
                end else begin
                    ende     = 1'b1;
                    state_nx = FETCH;
                    case (op)
                        OP_AI, OP_AW: begin
                            gpr_we = 1'b1;
                            gpr_wd = sum[31:0];
                            cc_we  = 1'b1;
                            cc_nx  = cc_value(sum[32], ovf, sum[31:0]);
                        end
                        OP_LI, OP_LW: begin
                            gpr_we = 1'b1;
                            gpr_wd = (op == OP_LI) ? imm : data_in;
                            cc_we  = 1'b1;
                            cc_nx  = cc_value(1'b0, 1'b0, gpr_wd);
                        end
                        OP_BCR:  if ((cc & ir[R_FIRST:R_LAST]) == 4'b0) q_nx = ea;
                        OP_BCS:  if ((cc & ir[R_FIRST:R_LAST]) != 4'b0) q_nx = ea;
                        OP_WAIT: state_nx = WAIT;
                        default: ;
                    endcase
                end
            end
            default: state_nx = state;
        endcase
    end

    // Architectural state; reset aborts any instruction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            ir       <= '0;
            ref_addr <= '0;
            q        <= RESET_PC;
            cc       <= '0;
            trap     <= 1'b0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            if (cc_we)    cc   <= cc_nx;
            if (set_trap) trap <= 1'b1;
            case (state)
                FETCH: begin
                    ir       <= data_in;
                    ref_addr <= data_in[A_FIRST:A_LAST];
                end
                INDIRECT: ref_addr <= data_in[A_FIRST:A_LAST];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sigma_cpu.sv
// Bench for sigma_cpu: directed programs plus random programs, each
// instruction checked against an instruction-level reference model.
module tb_sigma_cpu;

    localparam logic [6:0] AI = 7'h20, LI = 7'h22, WT = 7'h2E, AW = 7'h30,
                           LW = 7'h32, BCR = 7'h68, BCS = 7'h69;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [0:31]  data_in;
    logic [15:31] address;
    logic [6:0]   opcode;
    logic [16:0]  pc;
    logic         trap;
    logic         ende;

    logic [31:0] mem [1024];
    assign data_in = mem[address[22:31]];

    sigma_cpu dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .address (address),
        .opcode  (opcode),
        .pc      (pc),
        .trap    (trap),
        .ende    (ende)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one call executes one whole instruction.
    logic [31:0] m_r [16];
    logic [16:0] m_pc;
    logic [3:0]  m_cc;   // {CC1, CC2, CC3, CC4}
    logic [6:0]  m_op;
    bit          m_trap, m_halt;

    task automatic m_reset();
        foreach (m_r[i]) m_r[i] = '0;
        m_pc = '0; m_cc = '0; m_op = '0; m_trap = 0; m_halt = 0;
    endtask

    task automatic m_step(output int cyc);
        logic [31:0] w, imm, opnd, res, a;
        logic [32:0] wide;
        logic [16:0] ref_a, ea;
        logic [3:0]  r;
        logic [2:0]  x;
        bit          ind, memref, ovf;
        w   = mem[m_pc[9:0]];
        ind = w[31];
        m_op = w[30:24];
        r   = w[23:20];
        x   = w[19:17];
        imm = {{12{w[19]}}, w[19:0]};
        m_pc = m_pc + 17'd1;
        memref = m_op inside {AW, LW, BCR, BCS};
        ref_a = w[16:0];
        cyc = 2;
        if (ind && memref) begin
            ref_a = mem[ref_a[9:0]][16:0];
            cyc = 3;
        end
        ea = ref_a + ((x != 3'd0) ? m_r[x][16:0] : 17'd0);
        if (!(m_op inside {AI, LI, WT, AW, LW, BCR, BCS}) || (ind && (m_op inside {AI, LI, WT}))) begin
            m_trap = 1; m_halt = 1;
            return;
        end
        case (m_op)
            AI, AW: begin
                a    = m_r[r];
                opnd = (m_op == AI) ? imm : mem[ea[9:0]];
                wide = {1'b0, a} + {1'b0, opnd};
                res  = wide[31:0];
                ovf  = (($signed(a) < 0) == ($signed(opnd) < 0)) && (($signed(res) < 0) != ($signed(a) < 0));
                m_cc = {wide[32], ovf, $signed(res) > 0, $signed(res) < 0};
                m_r[r] = res;
            end
            LI, LW: begin
                res  = (m_op == LI) ? imm : mem[ea[9:0]];
                m_cc = {2'b00, $signed(res) > 0, $signed(res) < 0};
                m_r[r] = res;
            end
            BCR: if ((m_cc & r) == 4'd0) m_pc = ea;
            BCS: if ((m_cc & r) != 4'd0) m_pc = ea;
            default: m_halt = 1;   // WAIT
        endcase
    endtask

    task automatic check_state(input string pfx);
        chk({pfx, "_pc"}, pc, m_pc);
        chk({pfx, "_cc"}, dut.cc, m_cc);
        chk({pfx, "_opcode"}, opcode, m_op);
        chk({pfx, "_trap"}, trap, m_trap);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_r%0d", pfx, i), dut.u_rf.regs[i], m_r[i]);
    endtask

    // Run one instruction on both sides; measure its length via ende / trap.
    task automatic step_check(input string pfx);
        int cyc, n;
        bit seen_ende, seen_trap;
        m_step(cyc);
        n = 0; seen_ende = 0; seen_trap = 0;
        while (!seen_ende && !seen_trap && n < 8) begin
            @(negedge clock);
            n++;
            if (ende) seen_ende = 1;
            else if (trap) seen_trap = 1;
        end
        if (m_trap) begin
            chk({pfx, "_trap_seen"}, seen_trap, 1);
            chk({pfx, "_trap_cycles"}, n - 1, cyc);
        end else begin
            chk({pfx, "_ende_seen"}, seen_ende, 1);
            chk({pfx, "_cycles"}, n, cyc);
            @(posedge clock); #1;
        end
        check_state(pfx);
    endtask

    task automatic run_prog(input string pfx, input int max_instr);
        int k = 0;
        while (!m_halt && k < max_instr) begin
            step_check(pfx);
            k++;
        end
    endtask

    // A halted machine must stay put with no completion pulses.
    task automatic halt_check(input string pfx);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk({pfx, "_hold_ende"}, ende, 0);
            chk({pfx, "_hold_pc"}, pc, m_pc);
            chk({pfx, "_hold_addr"}, address, m_pc);
            chk({pfx, "_hold_op"}, opcode, m_op);
            chk({pfx, "_hold_trap"}, trap, m_trap);
        end
    endtask

    // Assert reset mid-cycle (after the next rising edge) and check it clears at once.
    task automatic assert_reset(input string pfx);
        bit any_gpr;
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        any_gpr = 0;
        for (int i = 0; i < 16; i++) if (dut.u_rf.regs[i] != 0) any_gpr = 1;
        chk({pfx, "_rst_gpr"}, any_gpr, 0);
        chk({pfx, "_rst_pc"}, pc, 17'd0);
        chk({pfx, "_rst_trap"}, trap, 0);
        chk({pfx, "_rst_op"}, opcode, 7'd0);
        chk({pfx, "_rst_cc"}, dut.cc, 4'd0);
        chk({pfx, "_rst_ende"}, ende, 0);
    endtask

    task automatic release_reset();
        @(posedge clock); #2;
        reset = 1'b1;
        m_reset();
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = '0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] op;
        bit ind;
        case ($urandom_range(0, 19))
            0, 1, 2, 3:  op = AI;
            4, 5, 6:     op = LI;
            7, 8, 9:     op = AW;
            10, 11, 12:  op = LW;
            13, 14:      op = BCR;
            15, 16:      op = BCS;
            17:          op = WT;
            default:     op = 7'($urandom);
        endcase
        ind = ($urandom_range(0, 5) == 0);
        return {ind, op, 24'($urandom)};
    endfunction

    initial begin
        clear_mem();
        #12;
        chk("reset_pc", pc, 17'd0);
        chk("reset_trap", trap, 0);
        chk("reset_ende", ende, 0);
        chk("reset_op", opcode, 7'd0);
        chk("reset_addr", address, 17'd0);

        // P1: LI R1,5 ; WAIT
        mem[0] = 32'h22100005;
        mem[1] = 32'h2E000000;
        release_reset();
        run_prog("p1", 4);
        chk("p1_r1_const", dut.u_rf.regs[1], 32'h5);
        chk("p1_cc_const", dut.cc, 4'b0010);
        chk("p1_pc_const", pc, 17'd2);
        chk("p1_op_const", opcode, 7'h2E);
        halt_check("p1");

        // P2: carry then signed overflow
        assert_reset("p2");
        clear_mem();
        mem[0] = 32'h222FFFFF;   // LI R2,-1
        mem[1] = 32'h20200001;   // AI R2,1
        mem[2] = 32'h2237FFFF;   // LI R3,0x7FFFF
        mem[3] = 32'h30300060;   // AW R3,0x60
        mem[4] = 32'h2E000000;
        mem[32'h60] = 32'h7FFFFFFF;
        release_reset();
        step_check("p2");
        step_check("p2");
        chk("p2_r2_const", dut.u_rf.regs[2], 32'h0);
        chk("p2_carry_cc", dut.cc, 4'b1000);
        step_check("p2");
        step_check("p2");
        chk("p2_ovf_cc", dut.cc, 4'b0101);
        run_prog("p2", 2);

        // P3: direct, indexed, indirect loads and both branch senses
        assert_reset("p3");
        clear_mem();
        mem[0]  = 32'h32400040;  // LW R4,0x40
        mem[1]  = 32'h22500002;  // LI R5,2
        mem[2]  = 32'h324A003E;  // LW R4,0x3E,R5
        mem[3]  = 32'hB2400050;  // LW R4,*0x50
        mem[4]  = 32'h69100010;  // BCS 1,0x10  (taken)
        mem[16] = 32'h68100020;  // BCR 1,0x20  (not taken)
        mem[17] = 32'h2E000000;
        mem[32'h40] = 32'hDEADBEEF;
        mem[32'h50] = 32'h00000040;
        release_reset();
        run_prog("p3", 10);
        chk("p3_r4_const", dut.u_rf.regs[4], 32'hDEADBEEF);
        chk("p3_pc_const", pc, 17'h12);
        halt_check("p3");

        // P4: unimplemented opcode at word 3
        assert_reset("p4");
        clear_mem();
        mem[0] = 32'h22100005;   // LI R1,5
        mem[1] = 32'h201FFFFE;   // AI R1,-2
        mem[2] = 32'h22200007;   // LI R2,7
        mem[3] = 32'h00000000;
        release_reset();
        run_prog("p4", 8);
        chk("p4_trap_const", trap, 1);
        chk("p4_pc_const", pc, 17'd4);
        chk("p4_r1_const", dut.u_rf.regs[1], 32'h3);
        halt_check("p4");

        // Abort the third instruction in its EXEC cycle, then rerun from 0.
        assert_reset("p4a");
        release_reset();
        step_check("p4a");
        step_check("p4a");
        assert_reset("p4b");
        release_reset();
        run_prog("p4c", 8);
        halt_check("p4c");

        // Random programs
        for (int rnd = 0; rnd < 25; rnd++) begin
            assert_reset("rnd");
            foreach (mem[i]) mem[i] = ($urandom_range(0, 3) != 0) ? rnd_instr() : $urandom;
            release_reset();
            run_prog("rnd", 40);
            if (m_halt) halt_check("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sigma_cpu.md
Name: sigma_cpu

Overview:
- Small Sigma-style 32-bit CPU core with a fetch/execute state machine and a read-only memory port.
- Reads instructions and operands combinationally from word-addressed memory.
- Executes a reduced instruction subset and halts on WAIT or on any unimplemented opcode (trap).
- Sits at the top of the CPU subsystem beside a combinational-read RAM model.
- Status outputs drive bench termination and instruction counting.

Parameters:
- RESET_PC, 17'h00000, word address of the first instruction fetched after reset.

Ports:
- clock  input  1  single system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low. Low clears all state immediately; release is sampled on clock.
- data_in  input  32 [0:31]  memory read data, combinational function of address.
- address  output  17 [15:31]  word address, combinational from state.
- opcode  output  7  last fetched opcode, instruction bits 1-7.
- pc  output  17  Q register, the next-instruction address.
- trap  output  1  high and held once a trap occurs.
- ende  output  1  one-cycle pulse in the final cycle of every completed instruction.

Behaviour:
- Bit 0 is MSB throughout.
- Instruction format: I=bit0 (indirect), OP=bits1-7, R=bits8-11, X=bits12-14, ADDR=bits15-31. Immediate value = bits12-31, sign-extended to 32 bits.
- State: 16 x 32-bit GPRs, Q (17b), CC (4b, CC1..CC4), state register. Reset values: GPRs 0, Q=RESET_PC, CC 0, opcode 0, trap 0, ende 0, state FETCH.
- FETCH:
  - address=Q.
  - Latch data_in into the instruction register and opcode.
  - Q<=Q+1 (17-bit wrap).
  - Next state is INDIRECT if I=1 and the opcode is a memory-reference opcode, otherwise EXEC.
- INDIRECT (1 cycle): address=ADDR; the effective reference address becomes data_in[15:31]; then EXEC.
- EXEC (1 cycle):
  - EA = reference address + (X!=0 ? GPR[X][15:31] : 0), mod 2^17. Indexing is applied after indirection.
  - address=EA.
  - ende=1.
  - Next state FETCH, except for WAIT and trap.
- Opcodes (hex):
  - 20 AI: R<=R+imm.
  - 22 LI: R<=imm.
  - 30 AW: R<=R+M[EA].
  - 32 LW: R<=M[EA].
  - 68 BCR: Q<=EA if (CC & R[8:11])==0.
  - 69 BCS: Q<=EA if (CC & R[8:11])!=0.
  - 2E WAIT: enter WAIT; ende=1 in that cycle.
- CC update on AI/AW/LI/LW:
  - CC3 = result>0.
  - CC4 = result<0 (signed).
  - AI/AW only: CC1=carry out of bit 0, CC2=signed overflow.
  - LI/LW clear CC1/CC2.
  - Branches and WAIT leave CC unchanged.
  - Mask bit 8 of the R field corresponds to CC1.
- Trap conditions: any other opcode, or I=1 on AI/LI/WAIT.
  - Detected in EXEC.
  - trap<=1 and the machine enters TRAP.
  - No register or CC write; ende=0.
  - Q still equals faulting address+1.
- WAIT/TRAP:
  - Terminal until reset.
  - address=Q.
  - opcode, trap and Q held.
  - ende=0 after the entry cycle.
- R0 is a normal GPR; X=0 means no indexing.
- Same-instruction read/write of R (e.g. AW R,X with R==X) uses pre-update values.
- Reset asserted mid-instruction aborts it with no partial GPR write.
- Latency: immediate/register-direct instructions take 2 cycles; indirect adds 1 cycle.

Decomposition:
- sigma_pkg holds:
  - opcode constants (OP_AI, OP_LI, OP_AW, OP_LW, OP_BCR, OP_BCS, OP_WAIT);
  - state enum (FETCH, INDIRECT, EXEC, WAIT, TRAP);
  - instruction field bit positions;
  - CC bit indices.
- One sub-module, sigma_regfile: 16x32 registers, two asynchronous read ports (R, X), one synchronous write port, async active-low clear.

Test Plan:
- Reset then LI R1,5 (0x22100005), WAIT -> R1=0x00000005, CC3=1, ende pulses twice, halted with opcode=0x2E, pc=2.
- LI R2,-1; AI R2,1 -> R2=0, CC1=1 (carry), CC3=CC4=0; LI R3,0x7FFFF then AW with M=0x7FFFFFFF -> CC2=1 overflow.
- LW R4 from word 0x40=0xDEADBEEF, then again via index R5=2 on word 0x3E -> R4=0xDEADBEEF, CC4=1, 2 cycles each.
- Indirect LW: word 0x50 holds 0x40, I=1 ADDR=0x50 -> R4=M[0x40], instruction takes 3 cycles.
- BCS mask 1 after negative result -> branch taken to EA; BCR mask 1 -> not taken, pc advances by 1.
- Unimplemented opcode 0x00 at address 3 -> trap=1 held, pc=4, no ende that cycle, no GPR change. Then reset pulse low mid-run -> all state cleared, fetch restarts at 0.
